// File: rtl/ptp_pkg.sv
// Shared constants and FSM encoding for the PTP record queue unpacker.
//   RecW        : width of one FIFO record (four stream words)
//   WordW       : width of one stream word
//   ptp_state_e : unpacker FSM states
package ptp_pkg;

  localparam int unsigned RecW  = 128;
  localparam int unsigned WordW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLatch = 2'd1,
    StSend  = 2'd2
  } ptp_state_e;

endpackage

// File: rtl/ptp_queue_unpack.sv
// Pops 128-bit records from a normal-mode (non-showahead) FIFO and emits each
// as four 32-bit words on a valid/ready stream with start/end-of-record marks.
//   clk, rst_n           : clock, asynchronous active-low reset
//   enable               : permits starting a new record fetch
//   q_data/q_rdempty/
//   q_rdusedw/q_rdreq    : FIFO read side (data valid the cycle after q_rdreq)
//   m_data/m_valid/
//   m_ready/m_sop/m_eop  : word stream
//   pending              : records not yet fully emitted
module ptp_queue_unpack
  import ptp_pkg::*;
#(
  parameter int unsigned MSW_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [RecW-1:0]  q_data,
  input  logic             q_rdempty,
  input  logic [3:0]       q_rdusedw,
  output logic             q_rdreq,
  output logic [WordW-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [4:0]       pending
);

  ptp_state_e state_q, state_d;
  logic [RecW-1:0] hold_q, hold_d;
  logic [1:0]      idx_q, idx_d;
  logic            can_fetch;
  logic            fire;
  logic            last;
  logic            fetch;
  logic [1:0]      sel;
  logic [3:0][WordW-1:0] words;

  assign can_fetch = enable & ~q_rdempty;
  assign m_valid   = (state_q == StSend);
  assign fire      = m_valid & m_ready;
  assign last      = (idx_q == 2'd3);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    fetch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_fetch) begin
          fetch   = 1'b1;
          state_d = StLatch;
        end
      end
      StLatch: begin
        hold_d  = q_data;
        idx_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        if (fire) begin
          if (last) begin
            // Record boundary: chain straight into the next fetch if allowed.
            if (can_fetch) begin
              fetch   = 1'b1;
              state_d = StLatch;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset holds state in StIdle, where enable alone would otherwise pop.
  assign q_rdreq = fetch & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  // words[3] is record bits [127:96].
  assign words  = hold_q;
  assign sel    = (MSW_FIRST != 0) ? (2'd3 - idx_q) : idx_q;
  assign m_data = words[sel];
  assign m_sop  = m_valid & (idx_q == 2'd0);
  assign m_eop  = m_valid & last;

  assign pending = {1'b0, q_rdusedw} + {4'd0, (state_q != StIdle)};

endmodule

// File: tb/tb_ptp_queue_unpack.sv
module tb_ptp_queue_unpack;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         enable    = 1'b0;
  logic         m_ready   = 1'b0;
  logic [127:0] q_data    = '0;
  logic         q_rdempty = 1'b1;
  logic [3:0]   q_rdusedw = '0;

  logic        q_rdreq_a, m_valid_a, m_sop_a, m_eop_a;
  logic [31:0] m_data_a;
  logic [4:0]  pending_a;
  logic        q_rdreq_b, m_valid_b, m_sop_b, m_eop_b;
  logic [31:0] m_data_b;
  logic [4:0]  pending_b;

  ptp_queue_unpack #(.MSW_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .q_data(q_data), .q_rdempty(q_rdempty),
    .q_rdusedw(q_rdusedw), .q_rdreq(q_rdreq_a), .m_data(m_data_a), .m_valid(m_valid_a),
    .m_ready(m_ready), .m_sop(m_sop_a), .m_eop(m_eop_a), .pending(pending_a)
  );

  ptp_queue_unpack #(.MSW_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .q_data(q_data), .q_rdempty(q_rdempty),
    .q_rdusedw(q_rdusedw), .q_rdreq(q_rdreq_b), .m_data(m_data_b), .m_valid(m_valid_b),
    .m_ready(m_ready), .m_sop(m_sop_b), .m_eop(m_eop_b), .pending(pending_b)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] Rec0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] Rec1 = 128'hA0A1A2A3B0B1B2B3C0C1C2C3D0D1D2D3;

  // FIFO model: normal mode, data registered on the edge that sees q_rdreq.
  logic [127:0] fifo_q[$];
  logic         pop_flag = 1'b0;
  always @(posedge clk) begin
    pop_flag <= q_rdreq_a;
    if (q_rdreq_a && fifo_q.size() > 0) q_data <= fifo_q[0];
  end

  // Reference: a queue of words still owed downstream, plus one record in
  // transit from the FIFO (popped but not yet available as words).
  typedef struct packed {
    logic [127:0] rec;
    logic [1:0]   pos;
  } word_t;
  word_t        stream_q[$];
  bit           arriving = 1'b0;
  logic [127:0] arr_rec  = '0;
  bit           prev_rdreq = 1'b0;
  bit           prev_fire  = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdreq_cnt = 0;

  logic [31:0] seen_a[$];
  logic [31:0] seen_b[$];
  bit          seen_sop[$];
  bit          seen_eop[$];
  int          seen_cyc[$];
  int          seen_pend[$];

  logic [31:0] lit_msw[4];
  logic [31:0] lit_lsw[4];

  function automatic logic [31:0] word_of(input logic [127:0] rec, input int pos, input bit msw);
    logic [127:0] s;
    int k;
    k = msw ? pos : 3 - pos;
    s = rec << (32 * k);
    return s[127:96];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_seen();
    seen_a.delete();
    seen_b.delete();
    seen_sop.delete();
    seen_eop.delete();
    seen_cyc.delete();
    seen_pend.delete();
    rdreq_cnt = 0;
  endtask

  // One clock cycle: retire the previous edge, apply inputs, compare.
  task automatic step(input bit push, input logic [127:0] rec, input bit en, input bit rdy,
                      input bit rstn);
    bit exp_valid;
    bit exp_rdreq;
    int exp_pend;
    @(negedge clk);
    cyc++;
    if (prev_fire) void'(stream_q.pop_front());
    if (arriving) begin
      for (int i = 0; i < 4; i++) stream_q.push_back('{rec: arr_rec, pos: 2'(i)});
      arriving = 1'b0;
    end
    if (prev_rdreq && fifo_q.size() > 0) begin
      arriving = 1'b1;
      arr_rec  = fifo_q[0];
    end
    if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push && fifo_q.size() < 15) fifo_q.push_back(rec);
    enable  = en;
    m_ready = rdy;
    rst_n   = rstn;
    if (!rstn) begin
      stream_q.delete();
      arriving = 1'b0;
    end
    q_rdempty = (fifo_q.size() == 0);
    q_rdusedw = 4'(fifo_q.size());
    #1;
    exp_valid = rstn && stream_q.size() > 0;
    exp_rdreq = rstn && en && fifo_q.size() > 0 && !arriving &&
                (stream_q.size() == 0 || (stream_q.size() == 1 && rdy));
    exp_pend  = fifo_q.size() + ((arriving || stream_q.size() > 0) ? 1 : 0);
    chk("rdreq_a", q_rdreq_a, exp_rdreq);
    chk("rdreq_b", q_rdreq_b, exp_rdreq);
    chk("valid_a", m_valid_a, exp_valid);
    chk("valid_b", m_valid_b, exp_valid);
    chk("pending_a", pending_a, exp_pend);
    chk("pending_b", pending_b, exp_pend);
    if (exp_valid) begin
      chk("data_a", m_data_a, word_of(stream_q[0].rec, stream_q[0].pos, 1'b1));
      chk("data_b", m_data_b, word_of(stream_q[0].rec, stream_q[0].pos, 1'b0));
      chk("sop_a", m_sop_a, stream_q[0].pos == 2'd0);
      chk("eop_a", m_eop_a, stream_q[0].pos == 2'd3);
      chk("sop_b", m_sop_b, stream_q[0].pos == 2'd0);
      chk("eop_b", m_eop_b, stream_q[0].pos == 2'd3);
    end else if (!rstn) begin
      chk("rst_data_a", m_data_a, 0);
      chk("rst_data_b", m_data_b, 0);
      chk("rst_sop_a", m_sop_a, 0);
      chk("rst_eop_a", m_eop_a, 0);
    end
    if (m_valid_a && rdy) begin
      seen_a.push_back(m_data_a);
      seen_b.push_back(m_data_b);
      seen_sop.push_back(m_sop_a);
      seen_eop.push_back(m_eop_a);
      seen_cyc.push_back(cyc);
      seen_pend.push_back(int'(pending_a));
    end
    if (q_rdreq_a) rdreq_cnt++;
    prev_fire  = exp_valid && rdy;
    prev_rdreq = exp_rdreq;
  endtask

  task automatic idle_n(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, en, rdy, 1'b1);
  endtask

  task automatic run_until_seen(input int n);
    int guard;
    guard = 0;
    while (seen_a.size() < n && guard < 60) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("wait_words", seen_a.size() >= n, 1);
  endtask

  initial begin
    lit_msw = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    lit_lsw = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};

    // Reset with enable low.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Single record, both word orders.
    clear_seen();
    step(1'b1, Rec0, 1'b1, 1'b1, 1'b1);
    idle_n(8, 1'b1, 1'b1);
    chk("single_count", seen_a.size(), 4);
    chk("single_rdreq", rdreq_cnt, 1);
    if (seen_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("single_msw", seen_a[i], lit_msw[i]);
        chk("single_lsw", seen_b[i], lit_lsw[i]);
        chk("single_consec", seen_cyc[i] - seen_cyc[0], i);
      end
      chk("single_sop", seen_sop[0], 1);
      chk("single_eop", seen_eop[3], 1);
    end

    // Backpressure at index 1 with another record waiting.
    clear_seen();
    step(1'b1, Rec0, 1'b1, 1'b1, 1'b1);
    step(1'b1, Rec1, 1'b1, 1'b1, 1'b1);
    run_until_seen(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("stall_data", m_data_a, 32'h44556677);
      chk("stall_valid", m_valid_a, 1);
      chk("stall_rdreq", q_rdreq_a, 0);
    end
    idle_n(20, 1'b1, 1'b1);
    chk("stall_count", seen_a.size(), 8);
    if (seen_a.size() == 8) chk("stall_word5", seen_a[4], 32'hA0A1A2A3);

    // Back-to-back: three records, one bubble between each.
    clear_seen();
    for (int i = 0; i < 3; i++)
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1);
    chk("b2b_pend_start", pending_a, 3);
    idle_n(20, 1'b1, 1'b1);
    chk("b2b_count", seen_a.size(), 12);
    chk("b2b_rdreq", rdreq_cnt, 3);
    chk("b2b_pend_end", pending_a, 0);
    if (seen_a.size() == 12) begin
      for (int i = 1; i < 12; i++)
        chk("b2b_gap", seen_cyc[i] - seen_cyc[i-1], (i % 4 == 0) ? 2 : 1);
      chk("b2b_pend_r0", seen_pend[0], 3);
      chk("b2b_pend_r1", seen_pend[4], 2);
      chk("b2b_pend_r2", seen_pend[8], 1);
    end

    // Enable drop at index 2: record finishes, then nothing more is fetched.
    clear_seen();
    for (int i = 0; i < 3; i++)
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1);
    run_until_seen(2);
    idle_n(10, 1'b0, 1'b1);
    chk("endrop_count", seen_a.size(), 4);
    chk("endrop_usedw", q_rdusedw, 2);
    chk("endrop_rdreq", q_rdreq_a, 0);
    chk("endrop_valid", m_valid_a, 0);
    chk("endrop_pend", pending_a, 2);
    idle_n(25, 1'b1, 1'b1);
    chk("drain_pend", pending_a, 0);

    // Reset mid-record: popped record is lost, next one starts cleanly.
    clear_seen();
    step(1'b1, Rec0, 1'b0, 1'b1, 1'b1);
    step(1'b1, Rec1, 1'b0, 1'b1, 1'b1);
    run_until_seen(1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rst_valid", m_valid_a, 0);
    chk("rst_pend", pending_a, 1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    clear_seen();
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("rst_resume_rdreq", q_rdreq_a, 1);
    idle_n(8, 1'b1, 1'b1);
    chk("rst_resume_count", seen_a.size(), 4);
    if (seen_a.size() == 4) begin
      chk("rst_resume_sop", seen_sop[0], 1);
      chk("rst_resume_word", seen_a[0], 32'hA0A1A2A3);
    end

    // Randomized traffic, enable, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 3) == 0, {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 300) != 0);
    idle_n(80, 1'b1, 1'b1);
    chk("final_pend", pending_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
